// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Desc     : Shared decode constants, FSM states and op classes for the ALU sequencer.
// Revision : 1.0
// ============================================================================
package alu_seq_pkg;

    localparam int DEC_W = 12;
    localparam int CNT_W = 8;

    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    // Decode word is {1'b0, funct7[5], funct3, opcode}; bit 11 is always zero for legal ops.
    localparam logic [DEC_W-1:0] DEC_ADDI  = {1'b0, 1'b0, 3'b000, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_SLTI  = {1'b0, 1'b0, 3'b010, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_SLTIU = {1'b0, 1'b0, 3'b011, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_XORI  = {1'b0, 1'b0, 3'b100, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_ORI   = {1'b0, 1'b0, 3'b110, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_ANDI  = {1'b0, 1'b0, 3'b111, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_SLLI  = {1'b0, 1'b0, 3'b001, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_SRLI  = {1'b0, 1'b0, 3'b101, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_SRAI  = {1'b0, 1'b1, 3'b101, OPC_OPIMM};
    localparam logic [DEC_W-1:0] DEC_ADD   = {1'b0, 1'b0, 3'b000, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_SUB   = {1'b0, 1'b1, 3'b000, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_SLL   = {1'b0, 1'b0, 3'b001, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_SLT   = {1'b0, 1'b0, 3'b010, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_SLTU  = {1'b0, 1'b0, 3'b011, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_XOR   = {1'b0, 1'b0, 3'b100, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_SRL   = {1'b0, 1'b0, 3'b101, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_SRA   = {1'b0, 1'b1, 3'b101, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_OR    = {1'b0, 1'b0, 3'b110, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_AND   = {1'b0, 1'b0, 3'b111, OPC_OP};
    localparam logic [DEC_W-1:0] DEC_BEQ   = {1'b0, 1'b0, 3'b000, OPC_BRANCH};
    localparam logic [DEC_W-1:0] DEC_BNE   = {1'b0, 1'b0, 3'b001, OPC_BRANCH};
    localparam logic [DEC_W-1:0] DEC_BLT   = {1'b0, 1'b0, 3'b100, OPC_BRANCH};
    localparam logic [DEC_W-1:0] DEC_BGE   = {1'b0, 1'b0, 3'b101, OPC_BRANCH};
    localparam logic [DEC_W-1:0] DEC_BLTU  = {1'b0, 1'b0, 3'b110, OPC_BRANCH};
    localparam logic [DEC_W-1:0] DEC_BGEU  = {1'b0, 1'b0, 3'b111, OPC_BRANCH};
    localparam logic [DEC_W-1:0] DEC_LUI   = {1'b0, 1'b0, 3'b000, OPC_LUI};
    localparam logic [DEC_W-1:0] DEC_AUIPC = {1'b0, 1'b0, 3'b000, OPC_AUIPC};

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} seq_state_e;

    typedef enum logic [1:0] {CL_ARITH, CL_BRANCH, CL_SHIFT, CL_BAD} op_class_e;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Desc     : Request, ALU and response bundle; master = sequencer, slave = its peers.
// Revision : 1.0
// ============================================================================
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [DEC_W-1:0] req_decinst;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [31:0]      req_imm;

    logic             alu_en;
    logic [DEC_W-1:0] alu_decinst;
    logic [31:0]      alu_rs1;
    logic [31:0]      alu_rs2;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_rd;
    logic             alu_cmp;
    logic             alu_carry;
    logic             alu_is_rd;
    logic             alu_is_inst;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_cmp;
    logic             rsp_carry;
    logic             rsp_we;
    logic             rsp_err;

    modport master (
        input  req_valid, req_decinst, req_rs1, req_rs2, req_imm,
        output req_ready,
        output alu_en, alu_decinst, alu_rs1, alu_rs2, alu_imm,
        input  alu_rd, alu_cmp, alu_carry, alu_is_rd, alu_is_inst,
        output rsp_valid, rsp_data, rsp_cmp, rsp_carry, rsp_we, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_decinst, req_rs1, req_rs2, req_imm,
        input  req_ready,
        input  alu_en, alu_decinst, alu_rs1, alu_rs2, alu_imm,
        output alu_rd, alu_cmp, alu_carry, alu_is_rd, alu_is_inst,
        input  rsp_valid, rsp_data, rsp_cmp, rsp_carry, rsp_we, rsp_err,
        output rsp_ready
    );

endinterface
`default_nettype wire

// File: rtl/alu_op_class.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_class
// Desc     : Combinational map from ALU decode word to operation class.
// Revision : 1.0
// ============================================================================
module alu_op_class
    import alu_seq_pkg::*;
(
    input  wire logic [DEC_W-1:0] i_decinst,
    output op_class_e             o_class
);

    always_comb begin
        o_class = CL_BAD;
        case (i_decinst)
            DEC_ADDI, DEC_SLTI, DEC_SLTIU, DEC_XORI, DEC_ORI, DEC_ANDI,
            DEC_ADD, DEC_SUB, DEC_SLT, DEC_SLTU, DEC_XOR, DEC_OR, DEC_AND,
            DEC_LUI, DEC_AUIPC:
                o_class = CL_ARITH;
            DEC_SLLI, DEC_SRLI, DEC_SRAI, DEC_SLL, DEC_SRL, DEC_SRA:
                o_class = CL_SHIFT;
            DEC_BEQ, DEC_BNE, DEC_BLT, DEC_BGE, DEC_BLTU, DEC_BGEU:
                o_class = CL_BRANCH;
            default:
                o_class = CL_BAD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Desc     : Issues one op at a time to the multi-cycle ALU and returns a registered result.
// Revision : 1.0
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int FIX_LAT = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        flush,
    alu_sequencer_if.master  bus
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_FIX_LAT = CNT_W'(FIX_LAT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    seq_state_e       r_state;
    seq_state_e       w_next;
    op_class_e        w_class;
    logic             w_accept;
    logic             w_done;
    logic             w_tmo;

    logic [CNT_W-1:0] r_cyc_cnt;
    logic             r_is_shift;
    logic [DEC_W-1:0] r_decinst;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [31:0]      r_imm;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_cmp;
    logic             r_rsp_carry;
    logic             r_rsp_we;
    logic             r_rsp_err;

    alu_op_class u_op_class (
        .i_decinst (bus.req_decinst),
        .o_class   (w_class)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = (w_class == CL_BAD) ? RESP : LOAD;
                end
            end
            LOAD: w_next = EXEC;
            EXEC: begin
                // Shifts finish whenever the shifter drains; everything else has a fixed slot.
                if (bus.alu_is_inst && (r_is_shift || (r_cyc_cnt == C_FIX_LAT))) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end else if (r_cyc_cnt == C_TIMEOUT) begin
                    w_tmo  = 1'b1;
                    w_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (flush) begin
            w_next   = IDLE;
            w_accept = 1'b0;
            w_done   = 1'b0;
            w_tmo    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc_cnt   <= '0;
            r_is_shift  <= 1'b0;
            r_decinst   <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_rsp_data  <= '0;
            r_rsp_cmp   <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (flush) begin
            r_cyc_cnt   <= '0;
            r_is_shift  <= 1'b0;
            r_decinst   <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_rsp_data  <= '0;
            r_rsp_cmp   <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_decinst   <= bus.req_decinst;
                r_rs1       <= bus.req_rs1;
                r_rs2       <= bus.req_rs2;
                r_imm       <= bus.req_imm;
                r_is_shift  <= (w_class == CL_SHIFT);
                r_rsp_data  <= '0;
                r_rsp_cmp   <= 1'b0;
                r_rsp_carry <= 1'b0;
                r_rsp_we    <= 1'b0;
                r_rsp_err   <= (w_class == CL_BAD);
            end
            if (r_state == LOAD) begin
                r_cyc_cnt <= '0;
            end else if ((r_state == EXEC) && (r_cyc_cnt != C_CNT_MAX)) begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end
            // alu_rd is undriven unless alu_is_rd, so it must never reach rsp_data otherwise.
            if (w_done) begin
                r_rsp_data  <= bus.alu_is_rd ? bus.alu_rd : 32'h0;
                r_rsp_cmp   <= bus.alu_cmp;
                r_rsp_carry <= bus.alu_carry;
                r_rsp_we    <= bus.alu_is_rd;
                r_rsp_err   <= 1'b0;
            end
            if (w_tmo) begin
                r_rsp_data  <= '0;
                r_rsp_cmp   <= 1'b0;
                r_rsp_carry <= 1'b0;
                r_rsp_we    <= 1'b0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.alu_en      = (r_state == EXEC);
    assign bus.alu_decinst = r_decinst;
    assign bus.alu_rs1     = r_rs1;
    assign bus.alu_rs2     = r_rs2;
    assign bus.alu_imm     = r_imm;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_cmp     = r_rsp_cmp;
    assign bus.rsp_carry   = r_rsp_carry;
    assign bus.rsp_we      = r_rsp_we;
    assign bus.rsp_err     = r_rsp_err;

endmodule
`default_nettype wire
